// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns field-level RV32I instruction descriptors into 32-bit machine words
// and streams them into instruction memory at consecutive word addresses.
// The boot/test loader uses it to fill instruction memory before the core is
// released from reset.
//
// Supported classes (in_class):
//   0 = R-type  (0110011)    1 = I-type addi class (0010011)
//   2 = LOAD    (0000011)    3 = STORE (0100011)
//   4 = BRANCH  (1100011)    5..7 = illegal, descriptor dropped
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a new program (only from IDLE or DONE)
//   in_valid/in_ready   descriptor handshake
//   in_class .. in_imm  descriptor fields, in_last marks the final descriptor
//   imem_we/addr/wdata  registered write request toward instruction memory
//   imem_ready          memory accepts the pending write this cycle
//   busy, done          state is RUN / DONE
//   err, err_code       sticky error flag and first error cause
//                       (1 = illegal class, 2 = immediate range, 3 = overflow)
//   count               words written since the last start
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ERR_CLASS    = 2'd1;
    localparam logic [1:0] ERR_IMM      = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    // Number of words the memory can hold; one extra bit so that the sum of
    // count and a pending write never wraps.
    localparam logic [ADDR_W+1:0] CAPACITY = (ADDR_W + 2)'(1) << ADDR_W;

    state_t            state;
    logic              last_taken;
    logic [31:0]       enc_word;
    logic              class_ok;
    logic              imm_ok;
    logic              overflow;
    logic              accept;
    logic              write_done;
    logic              reject;
    logic [1:0]        reject_code;
    logic [ADDR_W+1:0] committed;

    // Handshake and status decode. Once the final descriptor is taken the
    // encoder stops accepting until the next start.
    assign in_ready   = (state == RUN) && !last_taken && (!imem_we || imem_ready);
    assign accept     = in_valid && in_ready;
    assign write_done = imem_we && imem_ready;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    // Words already written plus the one sitting in the output register. The
    // pending word is counted so that a descriptor accepted back-to-back with
    // the final completing write cannot slip past the end of memory.
    assign committed = {1'b0, count} + (ADDR_W + 2)'(imem_we);
    assign overflow  = (committed >= CAPACITY);

    // Field packing per instruction format together with the legality checks
    // on class and immediate. I, LOAD and STORE need a 12-bit signed value,
    // i.e. imm[12] must be a copy of imm[11]; BRANCH offsets must be even.
    always_comb begin
        enc_word = '0;
        class_ok = 1'b1;
        imm_ok   = 1'b1;
        case (in_class)
            3'd0: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                imm_ok   = (in_imm[12] == in_imm[11]);
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                imm_ok   = (in_imm[12] == in_imm[11]);
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], OP_STORE};
                imm_ok   = (in_imm[12] == in_imm[11]);
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
                imm_ok   = !in_imm[0];
            end
            default: begin
                class_ok = 1'b0;
            end
        endcase
    end

    // Rejection cause, with overflow taking precedence over class and class
    // over the immediate check.
    always_comb begin
        reject      = overflow || !class_ok || !imm_ok;
        reject_code = ERR_IMM;
        if (overflow) begin
            reject_code = ERR_OVERFLOW;
        end else if (!class_ok) begin
            reject_code = ERR_CLASS;
        end
    end

    // Control FSM plus the one-entry output register. The address register
    // always points at the next free word, so a word loaded in the same cycle
    // a write completes automatically picks up the incremented address.
    // A program ends when the last word's write completes, or one cycle after
    // the last descriptor was taken if that descriptor was dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_taken <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        last_taken <= 1'b0;
                        imem_we    <= 1'b0;
                        imem_addr  <= BASE_ADDR;
                        err        <= 1'b0;
                        err_code   <= '0;
                        count      <= '0;
                    end
                end
                RUN: begin
                    if (write_done) begin
                        count     <= count + (ADDR_W + 1)'(1);
                        imem_addr <= imem_addr + ADDR_W'(1);
                        imem_we   <= 1'b0;
                    end
                    if (accept) begin
                        if (in_last) begin
                            last_taken <= 1'b1;
                        end
                        if (reject) begin
                            err <= 1'b1;
                            if (!err) begin
                                err_code <= reject_code;
                            end
                        end else begin
                            imem_we    <= 1'b1;
                            imem_wdata <= enc_word;
                        end
                    end
                    if (last_taken && (!imem_we || imem_ready)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Two instances share the descriptor bus:
// a default-sized one (ADDR_W=10) for encoding, stall, error and reset cases
// and a tiny one (ADDR_W=2) for the memory-full case. Only the selected
// instance is ever started while descriptors are driven; the other sits in
// IDLE or DONE with in_ready low. Expected writes are queued when a
// descriptor is issued and a monitor pops them as write handshakes occur.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_b;
    logic        start_s;
    logic        in_valid;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        in_last;
    logic        imem_ready;
    logic        sel_small;

    logic        b_in_ready, b_we, b_busy, b_done, b_err;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  b_code;
    logic [10:0] b_count;

    logic        s_in_ready, s_we, s_busy, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_code;
    logic [2:0]  s_count;

    exp_t exp_b[$];
    exp_t exp_s[$];
    int   checks;
    int   errors;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
        .clk(clk), .rst(rst), .start(start_b),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .imem_ready(imem_ready),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_code),
        .count(b_count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_small (
        .clk(clk), .rst(rst), .start(start_s),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .imem_ready(imem_ready),
        .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_code),
        .count(s_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every completed write handshake must match the oldest queued
    // expectation for that instance.
    always @(negedge clk) begin
        if (b_we && imem_ready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("[TB] FAIL big_write: unexpected write 0x%08h @%0d, want none",
                         b_wdata, b_addr);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                if (32'(b_addr) !== e.addr || b_wdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL big_write: got 0x%08h @%0d, want 0x%08h @%0d",
                             b_wdata, b_addr, e.data, e.addr);
                end
            end
        end
        if (s_we && imem_ready) begin
            checks++;
            if (exp_s.size() == 0) begin
                errors++;
                $display("[TB] FAIL small_write: unexpected write 0x%08h @%0d, want none",
                         s_wdata, s_addr);
            end else begin
                exp_t e;
                e = exp_s.pop_front();
                if (32'(s_addr) !== e.addr || s_wdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL small_write: got 0x%08h @%0d, want 0x%08h @%0d",
                             s_wdata, s_addr, e.data, e.addr);
                end
            end
        end
    end

    // Drives one descriptor until the selected instance accepts it, queueing
    // the expected write first when the descriptor should produce one.
    // Returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [2:0] cls, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [12:0] imm, input logic last,
                                 input logic push, input int exp_addr,
                                 input logic [31:0] exp_data);
        logic accepted;
        exp_t e;
        if (push) begin
            e.addr = 32'(exp_addr);
            e.data = exp_data;
            if (sel_small) exp_s.push_back(e);
            else exp_b.push_back(e);
        end
        in_class  = cls;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            @(negedge clk);
            if (sel_small ? s_in_ready : b_in_ready) accepted = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("handshake_accepted", {31'b0, accepted}, 32'd1);
    endtask

    task automatic doStart();
        @(posedge clk);
        #1;
        if (sel_small) start_s = 1'b1;
        else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDone();
        logic d;
        d = 1'b0;
        for (int c = 0; c < 40 && !d; c++) begin
            @(posedge clk);
            #1;
            d = sel_small ? s_done : b_done;
        end
        checkOutput("wait_done", {31'b0, d}, 32'd1);
    endtask

    task automatic checkResetBig(input string tag);
        checkOutput({tag, "_in_ready"}, {31'b0, b_in_ready}, 32'd0);
        checkOutput({tag, "_we"}, {31'b0, b_we}, 32'd0);
        checkOutput({tag, "_addr"}, 32'(b_addr), 32'd0);
        checkOutput({tag, "_wdata"}, b_wdata, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, b_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, b_done}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, b_err}, 32'd0);
        checkOutput({tag, "_err_code"}, 32'(b_code), 32'd0);
        checkOutput({tag, "_count"}, 32'(b_count), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        start_b    = 1'b0;
        start_s    = 1'b0;
        in_valid   = 1'b0;
        in_class   = '0;
        in_funct3  = '0;
        in_funct7  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        in_last    = 1'b0;
        imem_ready = 1'b1;
        sel_small  = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        checkResetBig("reset");
        checkOutput("reset_small_count", 32'(s_count), 32'd0);
        checkOutput("reset_small_we", {31'b0, s_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // addi x1,x0,5 as a one-word program
        $display("[TB] addi single word");
        doStart();
        checkOutput("start_busy", {31'b0, b_busy}, 32'd1);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b1, 0, 32'h00500093);
        checkOutput("addi_we", {31'b0, b_we}, 32'd1);
        checkOutput("addi_addr", 32'(b_addr), 32'd0);
        checkOutput("addi_wdata", b_wdata, 32'h00500093);
        @(posedge clk);
        #1;
        checkOutput("addi_count", 32'(b_count), 32'd1);
        checkOutput("addi_done", {31'b0, b_done}, 32'd1);

        // add x3,x1,x2 then sw x2,8(x1), back to back
        $display("[TB] add + sw back to back");
        doStart();
        checkOutput("restart_count", 32'(b_count), 32'd0);
        applyStimulus(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 0, 32'h002081B3);
        applyStimulus(3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1, 1'b1, 1, 32'h0020A423);
        checkOutput("sw_addr", 32'(b_addr), 32'd1);
        checkOutput("sw_wdata", b_wdata, 32'h0020A423);
        checkOutput("sw_count_mid", 32'(b_count), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("sw_done", {31'b0, b_done}, 32'd1);
        checkOutput("sw_count", 32'(b_count), 32'd2);

        // beq x1,x2,-4 as the last descriptor
        $display("[TB] beq last");
        doStart();
        applyStimulus(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 1'b1, 0, 32'hFE208EE3);
        checkOutput("beq_done_early", {31'b0, b_done}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("beq_done", {31'b0, b_done}, 32'd1);
        checkOutput("beq_in_ready", {31'b0, b_in_ready}, 32'd0);
        checkOutput("beq_count", 32'(b_count), 32'd1);

        // Immediate extremes, funct7 use and ignored fields
        $display("[TB] boundary encodings");
        doStart();
        applyStimulus(3'd1, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 13'h1800, 1'b0, 1'b1, 0, 32'h80000093);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h07FF, 1'b0, 1'b1, 1, 32'h7FF00093);
        applyStimulus(3'd3, 3'd2, 7'h55, 5'd9, 5'd2, 5'd3, 13'h1FFF, 1'b0, 1'b1, 2, 32'hFE312FA3);
        applyStimulus(3'd0, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 13'h0ABC, 1'b0, 1'b1, 3, 32'h40628233);
        applyStimulus(3'd4, 3'd1, 7'd0, 5'd7, 5'd1, 5'd2, 13'd16, 1'b0, 1'b1, 4, 32'h00209863);
        applyStimulus(3'd4, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 13'h1000, 1'b1, 1'b1, 5, 32'h80000063);
        waitDone();
        checkOutput("boundary_count", 32'(b_count), 32'd6);
        checkOutput("boundary_err", {31'b0, b_err}, 32'd0);

        // Back-pressure: word held stable while the memory stalls
        $display("[TB] stall");
        doStart();
        imem_ready = 1'b0;
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 13'd7, 1'b0, 1'b1, 0, 32'h00700113);
        fork
            applyStimulus(3'd2, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 13'd4, 1'b1, 1'b1, 1, 32'h0040A283);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("stall_we", {31'b0, b_we}, 32'd1);
                    checkOutput("stall_addr", 32'(b_addr), 32'd0);
                    checkOutput("stall_wdata", b_wdata, 32'h00700113);
                    checkOutput("stall_in_ready", {31'b0, b_in_ready}, 32'd0);
                end
                @(posedge clk);
                #1 imem_ready = 1'b1;
            end
        join
        checkOutput("stall_release_addr", 32'(b_addr), 32'd1);
        checkOutput("stall_release_wdata", b_wdata, 32'h0040A283);
        waitDone();
        checkOutput("stall_count", 32'(b_count), 32'd2);

        // First error is kept
        $display("[TB] illegal class then bad immediate");
        doStart();
        applyStimulus(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("illegal_err", {31'b0, b_err}, 32'd1);
        checkOutput("illegal_code", 32'(b_code), 32'd1);
        checkOutput("illegal_we", {31'b0, b_we}, 32'd0);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("second_err_code", 32'(b_code), 32'd1);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd1, 1'b1, 1'b1, 0, 32'h00100093);
        checkOutput("after_drop_addr", 32'(b_addr), 32'd0);
        waitDone();
        checkOutput("after_drop_count", 32'(b_count), 32'd1);

        // Immediate range error after a fresh start, dropped last branch
        $display("[TB] immediate range errors");
        doStart();
        checkOutput("start_clears_err", {31'b0, b_err}, 32'd0);
        checkOutput("start_clears_code", 32'(b_code), 32'd0);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("imm_range_code", 32'(b_code), 32'd2);
        applyStimulus(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'd3, 1'b1, 1'b0, 0, 32'd0);
        checkOutput("drop_last_done_early", {31'b0, b_done}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("drop_last_done", {31'b0, b_done}, 32'd1);
        checkOutput("drop_last_count", 32'(b_count), 32'd0);

        doStart();
        applyStimulus(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'd3, 1'b1, 1'b0, 0, 32'd0);
        checkOutput("odd_branch_code", 32'(b_code), 32'd2);
        checkOutput("odd_branch_we", {31'b0, b_we}, 32'd0);

        // Memory full on the 4-word instance
        $display("[TB] overflow");
        sel_small = 1'b1;
        doStart();
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0, 1'b1, 0, 32'h00100093);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd2, 1'b0, 1'b1, 1, 32'h00200093);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd3, 1'b0, 1'b1, 2, 32'h00300093);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd4, 1'b0, 1'b1, 3, 32'h00400093);
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 1'b0, 0, 32'd0);
        checkOutput("overflow_err", {31'b0, s_err}, 32'd1);
        checkOutput("overflow_code", 32'(s_code), 32'd3);
        checkOutput("overflow_count", 32'(s_count), 32'd4);
        checkOutput("overflow_addr_wrap", 32'(s_addr), 32'd0);
        checkOutput("overflow_we", {31'b0, s_we}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("overflow_done", {31'b0, s_done}, 32'd1);
        sel_small = 1'b0;

        // Asynchronous reset while a write is stalled
        $display("[TB] reset mid-write");
        doStart();
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0, 1'b1, 0, 32'h00100093);
        @(posedge clk);
        #1 imem_ready = 1'b0;
        applyStimulus(3'd1, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 13'd7, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("pre_reset_we", {31'b0, b_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkResetBig("async_reset");
        imem_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        checkOutput("big_queue_empty", 32'(exp_b.size()), 32'd0);
        checkOutput("small_queue_empty", 32'(exp_s.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
